irq_request_latch: RTL and testbench

Upstream capture stage for the 8-input active-low priority encoder. Synchronizes 8 asynchronous active-low request lines and holds each request as a pending bit until it is acknowledged. Presents the masked pending set to the encoder as an active-low vector. Each pending bit is cleared when the consumer returns the encoder's 3-bit code on a one-cycle ack pulse.

---
 rtl/irq_request_latch_pkg.sv | 16 +
 rtl/irq_request_latch_sync.sv | 23 ++
 rtl/irq_request_latch.sv | 75 +++++++
 tb/tb_irq_request_latch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/irq_request_latch_pkg.sv
// Shared constants and helpers for the interrupt request capture stage.
package irq_request_latch_pkg;

    localparam int IRQ_N      = 8;
    localparam int IRQ_CODE_W = 3;
    localparam logic [IRQ_N-1:0] IRQ_PEND_IDLE = 8'hFF;

    // Expands an encoder code into a one-hot source select.
    function automatic logic [IRQ_N-1:0] code_onehot(input logic [IRQ_CODE_W-1:0] code);
        logic [IRQ_N-1:0] sel;
        sel = '0;
        sel[code] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/irq_request_latch_sync.sv
// Single-bit multi-stage synchronizer; resets to the inactive (high) level.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// Synchronizes active-low requests and holds them pending until acknowledged.
// Build option IRQ_EDGE_EN selects edge capture with overrun tracking; default is level capture.
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_n,
    input  logic [N-1:0]          mask,
    input  logic                  ack,
    input  logic [IRQ_CODE_W-1:0] ack_code,
    output logic [N-1:0]          pend_n,
    output logic                  irq,
    output logic [N-1:0]          overrun
);

    logic [N-1:0] s;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] pending;
    logic [N-1:0] visible;

    for (genvar gi = 0; gi < N; gi++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (req_n[gi]),
            .q    (s[gi])
        );
    end

    assign clr = ack ? code_onehot(ack_code) : '0;

`ifdef IRQ_EDGE_EN
    logic [N-1:0] s_hist;
    logic [N-1:0] overrun_q;

    // Falling edge of the synchronized line: low now, high last cycle.
    assign set = ~s & s_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hist    <= '1;
            overrun_q <= '0;
        end else begin
            s_hist    <= s;
            overrun_q <= (set & pending & ~clr) | (overrun_q & ~clr);
        end
    end

    assign overrun = overrun_q;
`else
    assign set     = ~s;
    assign overrun = '0;
`endif

    // Set has priority over a same-edge clear so no request is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= set | (pending & ~clr);
        end
    end

    assign visible = pending & ~mask;
    assign pend_n  = ~visible;
    assign irq     = |visible;

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch; table vectors plus reset/latency sequences.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_code;
    logic [7:0] pend_n;
    logic       irq;
    logic [7:0] overrun;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] req_n;
        logic [7:0] mask;
        logic       ack;
        logic [2:0] code;
        logic [7:0] pend_n;
        logic       irq;
        logic [7:0] ovr;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] pend_n;
        logic       irq;
        logic [7:0] ovr;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    irq_request_latch #(.N(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_n   (req_n),
        .mask    (mask),
        .ack     (ack),
        .ack_code(ack_code),
        .pend_n  (pend_n),
        .irq     (irq),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] m, input logic a,
                                input logic [2:0] c, input logic [7:0] p, input logic i,
                                input logic [7:0] o);
        vec_t v;
        v.req_n = r; v.mask = m; v.ack = a; v.code = c;
        v.pend_n = p; v.irq = i; v.ovr = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] p, input logic i, input logic [7:0] o);
        chk({name, " pend_n"}, pend_n, p);
        chk({name, " irq"}, {7'd0, irq}, {7'd0, i});
        chk({name, " overrun"}, overrun, o);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; req_n = 8'h00; mask = 8'h00; ack = 1'b0; ack_code = 3'd0;

        // Reset holds outputs idle even with every request asserted.
        #2;
        chk_all("reset_async", 8'hFF, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk_all("reset_hold", 8'hFF, 1'b0, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(); chk("release_edge1", pend_n, 8'hFF);
        cycle(); chk("release_edge2", pend_n, 8'hFF);
        cycle(); chk("release_edge3", pend_n, 8'h00);
        chk("release_edge3 irq", {7'd0, irq}, 8'h01);

        req_n = 8'hFF;
        for (int k = 0; k < 4; k++) cycle();
        for (int k = 0; k < 8; k++) begin
            ack = 1'b1; ack_code = 3'(k);
            cycle();
        end
        ack = 1'b0; ack_code = 3'd0;
        chk_all("ack_all", 8'hFF, 1'b0, 8'h00);

`ifdef IRQ_EDGE_EN
        vecs.push_back(mk(8'hF7, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hF7, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h00));
        vecs.push_back(mk(8'hF7, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hF7, 1, 8'h08));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd3, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFE, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFE, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hFE, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hFE, 1, 8'h00));
        vecs.push_back(mk(8'hFE, 8'h00, 0, 3'd0, 8'hFE, 1, 8'h00));
        vecs.push_back(mk(8'hFE, 8'h00, 0, 3'd0, 8'hFE, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd0, 8'hFE, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'h7F, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'h7F, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h80, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'h7F, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h80, 1, 3'd7, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
`else
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hDF, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hDF, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hDF, 8'h00, 0, 3'd0, 8'hDF, 1, 8'h00));
        vecs.push_back(mk(8'hDF, 8'h00, 1, 3'd5, 8'hDF, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hDF, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd0, 8'hDF, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd5, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'h7B, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'h7B, 8'h00, 0, 3'd0, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h80, 0, 3'd0, 8'hFB, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h80, 0, 3'd0, 8'hFB, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 0, 3'd2, 8'h7B, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd7, 8'hFB, 1, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd2, 8'hFF, 0, 8'h00));
        vecs.push_back(mk(8'hFF, 8'h00, 1, 3'd5, 8'hFF, 0, 8'h00));
`endif

        // Each vector is consumed by one clock edge; its expectation is checked right after.
        for (int i = 0; i < vecs.size(); i++) begin
            req_n = vecs[i].req_n; mask = vecs[i].mask;
            ack = vecs[i].ack; ack_code = vecs[i].code;
            e.idx = i; e.pend_n = vecs[i].pend_n; e.irq = vecs[i].irq; e.ovr = vecs[i].ovr;
            sbq.push_back(e);
            cycle();
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sbq.pop_front();
                chk_all($sformatf("vec%0d", e.idx), e.pend_n, e.irq, e.ovr);
            end
        end
        ack = 1'b0; mask = 8'h00;

        // Reset mid-operation clears state without waiting for a clock edge.
        req_n = 8'h3C;
        for (int k = 0; k < 4; k++) cycle();
        chk("pre_reset pend_n", pend_n, 8'h3C);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("mid_reset", 8'hFF, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk_all("post_reset_edge1", 8'hFF, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
